// File: rtl/rxstr_match.sv
// 8N1 UART receiver feeding a fixed-string matcher; pulses match once per complete PATTERN,
// keeps a wrapping match count and exposes every good byte and framing errors.
//   state   | meaning
//   IDLE    | line idle, waiting for a falling edge on rx_s
//   START   | half-bit wait, confirm start bit is still low
//   DATA    | sample 8 data bits LSB first, one per DIV cycles
//   STOP    | sample stop bit; good -> rcv, low -> ferr
//   BREAK   | line held low after a framing error, wait for idle high
module rxstr_match #(
    parameter int          DIV     = 104,
    parameter logic [63:0] PATTERN = "Hola!...",
    parameter int          PLEN    = 8,
    parameter int          CW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx,
    output logic [7:0]    data,
    output logic          rcv,
    output logic          ferr,
    output logic          match,
    output logic [CW-1:0] count
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    localparam int             BW   = $clog2(DIV);
    localparam logic [BW-1:0]  FULL = BW'(DIV - 1);
    localparam logic [BW-1:0]  HALF = BW'(DIV / 2 - 1);
    localparam logic [2:0]     LAST = 3'(PLEN - 1);

    state_t          state_q, state_d;
    logic            rx_m_q, rx_s_q;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic [2:0]      bitn_q, bitn_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            rcv_q, rcv_d;
    logic            ferr_q, ferr_d;
    logic [2:0]      idx_q, idx_d;
    logic            match_q, match_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      pat_b [8];

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            pat_b[i] = PATTERN[63 - 8*i -: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q - 1'b1;
        bitn_d  = bitn_q;
        shift_d = shift_q;
        data_d  = data_q;
        rcv_d   = 1'b0;
        ferr_d  = 1'b0;
        idx_d   = idx_q;
        match_d = 1'b0;
        count_d = count_q;

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    bcnt_d  = HALF;
                end
            end
            S_START: begin
                if (bcnt_q == '0) begin
                    if (!rx_s_q) begin
                        state_d = S_DATA;
                        bcnt_d  = FULL;
                        bitn_d  = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (bcnt_q == '0) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bcnt_d  = FULL;
                    bitn_d  = bitn_q + 3'd1;
                    if (bitn_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (bcnt_q == '0) begin
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        rcv_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Restart-only matcher: a mismatching byte can only re-open the pattern at index 1.
        if (rcv_q) begin
            if (data_q == pat_b[idx_q]) begin
                if (idx_q == LAST) begin
                    match_d = 1'b1;
                    count_d = count_q + 1'b1;
                    idx_d   = 3'd0;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end else begin
                idx_d = (data_q == pat_b[0]) ? 3'd1 : 3'd0;
            end
        end else if (ferr_q) begin
            idx_d = 3'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= S_IDLE;
            bcnt_q  <= '0;
            bitn_q  <= 3'd0;
            shift_q <= 8'd0;
            data_q  <= 8'd0;
            rcv_q   <= 1'b0;
            ferr_q  <= 1'b0;
            idx_q   <= 3'd0;
            match_q <= 1'b0;
            count_q <= '0;
        end else begin
            rx_m_q  <= rx;
            rx_s_q  <= rx_m_q;
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            bitn_q  <= bitn_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            rcv_q   <= rcv_d;
            ferr_q  <= ferr_d;
            idx_q   <= idx_d;
            match_q <= match_d;
            count_q <= count_d;
        end
    end

    assign data  = data_q;
    assign rcv   = rcv_q;
    assign ferr  = ferr_q;
    assign match = match_q;
    assign count = count_q;
endmodule

// File: tb/tb_rxstr_match.sv
// Bench for rxstr_match: two instances (CW=8 and CW=2) share rx/rst; expected bytes and
// match counts are queued as frames are driven and popped when the DUT reports them.
module tb_rxstr_match;
    localparam int DIV = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [7:0]  a_data, b_data;
    logic        a_rcv, a_ferr, a_match, b_rcv, b_ferr, b_match;
    logic [7:0]  a_count;
    logic [1:0]  b_count;

    rxstr_match #(.DIV(DIV), .PATTERN("Hola!..."), .PLEN(8), .CW(8)) dut_a (
        .clk(clk), .rst(rst), .rx(rx), .data(a_data), .rcv(a_rcv),
        .ferr(a_ferr), .match(a_match), .count(a_count));

    rxstr_match #(.DIV(DIV), .PATTERN("Hola!..."), .PLEN(8), .CW(2)) dut_b (
        .clk(clk), .rst(rst), .rx(rx), .data(b_data), .rcv(b_rcv),
        .ferr(b_ferr), .match(b_match), .count(b_count));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_rcv = 0;
    int rcv_exp = 0, rcv_seen = 0, ferr_exp = 0, ferr_seen = 0;
    int match_exp = 0, match_seen = 0, coinc = 0;
    int midx = 0, mcount = 0;
    logic [7:0] byte_q [$];
    int         cnt_q  [$];
    logic [63:0] pat = "Hola!...";

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (a_rcv) begin
                rcv_seen++;
                last_rcv = cyc;
                if (byte_q.size() > 0) chk("rcv_data", 32'(a_data), 32'(byte_q.pop_front()));
            end
            if (a_ferr) ferr_seen++;
            if (a_rcv && a_ferr) coinc++;
            if (a_match) begin
                match_seen++;
                chk("match_lat", 32'(cyc - last_rcv), 32'd1);
                chk("match_b", 32'(b_match), 32'd1);
                if (cnt_q.size() > 0) begin
                    int e;
                    e = cnt_q.pop_front();
                    chk("count_a", 32'(a_count), 32'(e % 256));
                    chk("count_b", 32'(b_count), 32'(e % 4));
                end
            end
        end
    end

    function automatic logic [7:0] pbyte(input int i);
        return pat[63 - 8*i -: 8];
    endfunction

    task automatic model_byte(input logic [7:0] b);
        if (b == pbyte(midx)) begin
            if (midx == 7) begin
                midx = 0;
                mcount++;
                match_exp++;
                cnt_q.push_back(mcount);
            end else begin
                midx++;
            end
        end else begin
            midx = (b == pbyte(0)) ? 1 : 0;
        end
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rcv_exp++;
        byte_q.push_back(b);
        model_byte(b);
        drive_frame(b, 1'b1);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic settle_and_check(input string tag);
        rx = 1'b1;
        repeat (4*DIV) @(negedge clk);
        chk({tag, "_rcv_n"},   32'(rcv_seen),   32'(rcv_exp));
        chk({tag, "_ferr_n"},  32'(ferr_seen),  32'(ferr_exp));
        chk({tag, "_match_n"}, 32'(match_seen), 32'(match_exp));
        chk({tag, "_coinc"},   32'(coinc),      32'd0);
        chk({tag, "_cnt_a"},   32'(a_count),    32'(mcount % 256));
        chk({tag, "_cnt_b"},   32'(b_count),    32'(mcount % 4));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog timeout at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_data",  32'(a_data),  32'd0);
        chk("rst_rcv",   32'(a_rcv),   32'd0);
        chk("rst_ferr",  32'(a_ferr),  32'd0);
        chk("rst_match", 32'(a_match), 32'd0);
        chk("rst_count", 32'(a_count), 32'd0);
        rst = 1'b0;
        repeat (2*DIV) @(negedge clk);

        send_str("Hola!...");
        settle_and_check("t1");

        send_str("HHola!...");
        send_str("Hola!...");
        settle_and_check("t2");

        send_str("Hola?...");
        settle_and_check("t3a");
        send_str("Hola!...");
        settle_and_check("t3b");

        send_str("Ho");
        drive_frame(8'h6C, 1'b0);
        rx = 1'b0;
        repeat (2*DIV) @(negedge clk);
        rx = 1'b1;
        ferr_exp++;
        midx = 0;
        settle_and_check("t4a");
        chk("t4_data_held", 32'(a_data), 32'h6F);
        send_str("Hola!...");
        settle_and_check("t4b");

        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (2*DIV) @(negedge clk);
        chk("t5_glitch_rcv", 32'(rcv_seen), 32'(rcv_exp));
        send_byte(8'h41);
        settle_and_check("t5");

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mcount = 0;
        midx = 0;
        repeat (2*DIV) @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            send_str("Hola!...");
            settle_and_check("t6_pat");
        end
        rx = 1'b0;
        repeat (3*DIV) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_data",  32'(a_data),  32'd0);
        chk("t6_rst_rcv",   32'(a_rcv),   32'd0);
        chk("t6_rst_ferr",  32'(a_ferr),  32'd0);
        chk("t6_rst_match", 32'(b_match), 32'd0);
        chk("t6_rst_cnt_b", 32'(b_count), 32'd0);
        rx = 1'b1;
        mcount = 0;
        midx = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2*DIV) @(negedge clk);
        send_str("Hola!...");
        settle_and_check("t6_post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
